// File: rtl/ula_mc.sv
// ula_mc: small multi-cycle ALU.
//   Single-cycle ops (AND/OR/XOR/NOT/ADD/SUB/SHL/SHR, illegal) finish on the
//   accepting edge. MUL (shift-add) and DIVU (restoring) each iterate for BITS
//   cycles in CALC.
// Ports:
//   clk_in, rst_in (async, active-high)
//   start_in/op_in/a_in/b_in : request, sampled on rising edge in IDLE/DONE
//   busy_out                 : iterative op in progress
//   done_out                 : one-cycle result-valid pulse
//   result_out/result2_out   : primary result / MUL high half or DIV remainder
//   zero_out/carry_out/illegal_out : status, held until the next done_out
module ula_mc #(
  parameter int unsigned BITS = 8,
  parameter int unsigned OP   = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start_in,
  input  logic [OP-1:0]   op_in,
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [BITS-1:0] result_out,
  output logic [BITS-1:0] result2_out,
  output logic            zero_out,
  output logic            carry_out,
  output logic            illegal_out
);

  localparam int unsigned SW = $clog2(BITS);
  localparam int unsigned CW = $clog2(BITS);

  localparam logic [OP-1:0] OP_AND = OP'(0);
  localparam logic [OP-1:0] OP_OR  = OP'(1);
  localparam logic [OP-1:0] OP_XOR = OP'(2);
  localparam logic [OP-1:0] OP_NOT = OP'(3);
  localparam logic [OP-1:0] OP_ADD = OP'(4);
  localparam logic [OP-1:0] OP_SUB = OP'(5);
  localparam logic [OP-1:0] OP_SHL = OP'(6);
  localparam logic [OP-1:0] OP_SHR = OP'(7);
  localparam logic [OP-1:0] OP_MUL = OP'(8);
  localparam logic [OP-1:0] OP_DIV = OP'(9);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] hi_q, hi_d;     // MUL high partial product / DIV remainder
  logic [BITS-1:0] lo_q, lo_d;     // MUL multiplier->low product / DIV dividend->quotient
  logic [BITS-1:0] m_q, m_d;       // MUL multiplicand / DIV divisor
  logic            div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] res_q, res_d;
  logic [BITS-1:0] res2_q, res2_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            ill_q, ill_d;

  logic [BITS:0]   add_w, sub_w;
  logic [BITS-1:0] alu_r;
  logic            alu_c, alu_ill, is_iter;
  logic [BITS:0]   mul_sum, div_sh, div_tr;
  logic [BITS-1:0] step_hi, step_lo;

  // Single-cycle datapath works straight off the request inputs.
  always_comb begin
    add_w   = {1'b0, a_in} + {1'b0, b_in};
    sub_w   = {1'b0, a_in} - {1'b0, b_in};
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    is_iter = 1'b0;
    case (op_in)
      OP_AND: alu_r = a_in & b_in;
      OP_OR:  alu_r = a_in | b_in;
      OP_XOR: alu_r = a_in ^ b_in;
      OP_NOT: alu_r = ~a_in;
      OP_ADD: begin alu_r = add_w[BITS-1:0]; alu_c = add_w[BITS]; end
      OP_SUB: begin alu_r = sub_w[BITS-1:0]; alu_c = sub_w[BITS]; end
      OP_SHL: alu_r = a_in << b_in[SW-1:0];
      OP_SHR: alu_r = a_in >> b_in[SW-1:0];
      OP_MUL, OP_DIV: is_iter = 1'b1;
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration step. MUL and DIV share the {hi,lo} pair so that at the end
  // lo holds result_out and hi holds result2_out for both.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh  = {hi_q, lo_q[BITS-1]};
    div_tr  = div_sh - {1'b0, m_q};
    if (div_q) begin
      // Bit BITS of the trial difference is the borrow: restore on borrow.
      if (!div_tr[BITS]) begin
        step_hi = div_tr[BITS-1:0];
        step_lo = {lo_q[BITS-2:0], 1'b1};
      end else begin
        step_hi = div_sh[BITS-1:0];
        step_lo = {lo_q[BITS-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[BITS:1];
      step_lo = {mul_sum[0], lo_q[BITS-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    res2_d  = res2_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ill_d   = ill_q;
    case (state_q)
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS - 1)) begin
          state_d = DONE;
          res_d   = step_lo;
          res2_d  = step_hi;
          zero_d  = (step_lo == '0);
          carry_d = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (start_in) begin
          if (is_iter) begin
            state_d = CALC;
            div_d   = (op_in == OP_DIV);
            hi_d    = '0;
            lo_d    = (op_in == OP_DIV) ? a_in : b_in;
            m_d     = (op_in == OP_DIV) ? b_in : a_in;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            res_d   = alu_r;
            res2_d  = '0;
            zero_d  = (alu_r == '0);
            carry_d = alu_c;
            ill_d   = alu_ill;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      res2_q  <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      res2_q  <= res2_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ill_q   <= ill_d;
    end
  end

  assign busy_out    = (state_q == CALC);
  assign done_out    = (state_q == DONE);
  assign result_out  = res_q;
  assign result2_out = res2_q;
  assign zero_out    = zero_q;
  assign carry_out   = carry_q;
  assign illegal_out = ill_q;

endmodule
